// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : single-outstanding CPU-to-synchronous-memory access FSM
// Optional write-verify readback: define MEM_ACCESS_CTRL_VERIFY_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_adress,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_indata,
  input  logic [DATA_W-1:0] mem_outdata,
  output logic              vfy_err,
  output logic [7:0]        vfy_cnt
);

  localparam logic [2:0] c_rd_lat = 3'(RD_LAT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_VFY_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_adress;
  logic [DATA_W-1:0] r_indata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_write;
  logic              w_cnt_last;

  assign w_cnt_last = (r_cnt == 3'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (cpu_req) w_next = cpu_we ? ST_WR : ST_RD_WAIT;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
      ST_WR:      w_next = ST_VFY_WAIT;
      ST_VFY_WAIT: if (w_cnt_last) w_next = ST_DONE;
`else
      ST_WR:      w_next = ST_DONE;
`endif
      ST_RD_WAIT: if (w_cnt_last) w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_adress <= '0;
      r_indata <= '0;
      r_rdata  <= '0;
      r_write  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_adress <= cpu_addr;
            r_indata <= cpu_wdata;
            r_write  <= cpu_we;
            r_cnt    <= c_rd_lat;
          end
        end
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
        ST_WR:       r_cnt <= c_rd_lat;
        ST_VFY_WAIT: r_cnt <= r_cnt - 3'd1;
`endif
        ST_RD_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (w_cnt_last) r_rdata <= mem_outdata;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
  logic       r_vfy_err;
  logic [7:0] r_vfy_cnt;

  // Readback compare happens on the last cycle of the verify wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vfy_err <= 1'b0;
      r_vfy_cnt <= 8'd0;
    end else if (r_state == ST_VFY_WAIT && w_cnt_last && mem_outdata != r_indata) begin
      r_vfy_err <= 1'b1;
      if (r_vfy_cnt != 8'hFF) r_vfy_cnt <= r_vfy_cnt + 8'd1;
    end
  end

  assign vfy_err = r_vfy_err;
  assign vfy_cnt = r_vfy_cnt;
`else
  assign vfy_err = 1'b0;
  assign vfy_cnt = 8'd0;
`endif

  assign cpu_ready  = (r_state == ST_IDLE);
  assign cpu_done   = (r_state == ST_DONE);
  assign cpu_rdata  = r_rdata;
  assign mem_adress = r_adress;
  assign mem_write  = r_write;
  assign mem_indata = r_indata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl : scoreboard bench for mem_access_ctrl (RD_LAT 1 and 3)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  localparam int LAT = 1;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
  localparam int WDO  = LAT + 1;
  localparam int WDO3 = 4;
`else
  localparam int WDO  = 1;
  localparam int WDO3 = 1;
`endif

  typedef struct packed {
    int          cyc;
    logic [11:0] adr;
    logic [15:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, req = 1'b0, we = 1'b0, flip = 1'b0;
  logic [11:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        ready, done, mwr, verr;
  logic [11:0] madr;
  logic [15:0] rdata, mind, mout;
  logic [7:0]  vcnt;

  logic        r3 = 1'b1, req3 = 1'b0, we3 = 1'b0, d3_fin = 1'b0;
  logic [11:0] addr3 = '0;
  logic [15:0] wdata3 = '0;
  logic        ready3, done3, mwr3, verr3;
  logic [11:0] madr3;
  logic [15:0] rdata3, mind3, mout3;
  logic [7:0]  vcnt3;

  logic [15:0] mem  [0:4095];
  logic [15:0] mem3 [0:4095];
  exp_t        wq[$], dq[$], dq3[$];
  exp_t        ew, ed, ed3;
  logic [15:0] exp_rdata = '0;
  int          cyc = 0, n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl #(.ADDR_W(12), .DATA_W(16), .RD_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset), .cpu_req(req), .cpu_we(we), .cpu_addr(addr),
    .cpu_wdata(wdata), .cpu_ready(ready), .cpu_done(done), .cpu_rdata(rdata),
    .mem_adress(madr), .mem_write(mwr), .mem_indata(mind), .mem_outdata(mout),
    .vfy_err(verr), .vfy_cnt(vcnt));

  mem_access_ctrl #(.ADDR_W(12), .DATA_W(16), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(r3), .cpu_req(req3), .cpu_we(we3), .cpu_addr(addr3),
    .cpu_wdata(wdata3), .cpu_ready(ready3), .cpu_done(done3), .cpu_rdata(rdata3),
    .mem_adress(madr3), .mem_write(mwr3), .mem_indata(mind3), .mem_outdata(mout3),
    .vfy_err(verr3), .vfy_cnt(vcnt3));

  // Behavioural memories: synchronous write, asynchronous read.
  always @(posedge clk) if (mwr) mem[madr] <= mind;
  always @(posedge clk) if (mwr3) mem3[madr3] <= mind3;
  assign mout  = mem[madr] ^ {15'd0, (flip && madr == 12'h010)};
  assign mout3 = mem3[madr3];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor for the RD_LAT=1 instance
  always @(negedge clk) begin
    if (mwr === 1'b1) begin
      if (wq.size() == 0) chk("mem_write_unexpected", 32'd1, 32'd0);
      else begin
        ew = wq.pop_front();
        chk("wr_cycle", cyc, ew.cyc);
        chk("wr_addr", {20'd0, madr}, {20'd0, ew.adr});
        chk("wr_data", {16'd0, mind}, {16'd0, ew.dat});
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else begin
        ed = dq.pop_front();
        chk("done_cycle", cyc, ed.cyc);
        chk("done_addr", {20'd0, madr}, {20'd0, ed.adr});
        chk("done_rdata", {16'd0, rdata}, {16'd0, ed.dat});
        chk("done_ready_low", {31'd0, ready}, 32'd0);
      end
    end
  end

  // Monitor for the RD_LAT=3 instance
  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (dq3.size() == 0) chk("lat3_done_unexpected", 32'd1, 32'd0);
      else begin
        ed3 = dq3.pop_front();
        chk("lat3_done_cycle", cyc, ed3.cyc);
        chk("lat3_rdata", {16'd0, rdata3}, {16'd0, ed3.dat});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic issue(input logic w, input logic [11:0] a, input logic [15:0] d,
                       input logic [15:0] erd);
    int t;
    wait_ready();
    req = 1'b1; we = w; addr = a; wdata = d;
    t = cyc + 1;
    if (w) begin
      wq.push_back('{t, a, d});
      dq.push_back('{t + WDO, a, exp_rdata});
    end else begin
      exp_rdata = erd;
      dq.push_back('{t + LAT, a, erd});
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  // Independent RD_LAT=3 sequence: write then read back 0x0A5.
  initial begin
    int t, n;
    repeat (3) @(negedge clk);
    r3 = 1'b0;
    req3 = 1'b1; we3 = 1'b1; addr3 = 12'h0A5; wdata3 = 16'h1234;
    t = cyc + 1;
    dq3.push_back('{t + WDO3, 12'h0A5, 16'h0000});
    @(negedge clk);
    req3 = 1'b0;
    n = 0;
    while (ready3 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req3 = 1'b1; we3 = 1'b0;
    t = cyc + 1;
    dq3.push_back('{t + 3, 12'h0A5, 16'h1234});
    @(negedge clk);
    req3 = 1'b0;
    repeat (10) @(negedge clk);
    d3_fin = 1'b1;
  end

  initial begin
    int t, n;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_write", {31'd0, mwr}, 32'd0);
    chk("rst_mem_adress", {20'd0, madr}, 32'd0);
    chk("rst_mem_indata", {16'd0, mind}, 32'd0);
    chk("rst_cpu_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_vfy_err", {31'd0, verr}, 32'd0);
    chk("rst_vfy_cnt", {24'd0, vcnt}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b1, 12'h0A5, 16'h1234, 16'h0);
    issue(1'b0, 12'h0A5, 16'h0, 16'h1234);
    issue(1'b1, 12'h0A6, 16'hBEEF, 16'h0);
    issue(1'b0, 12'h0A6, 16'h0, 16'hBEEF);

    // cpu_req held through busy cycles: one accept per IDLE visit.
    wait_ready();
    req = 1'b1; we = 1'b1; addr = 12'h0A7; wdata = 16'h00FF;
    t = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      wq.push_back('{t + k * (WDO + 2), 12'h0A7, 16'h00FF});
      dq.push_back('{t + k * (WDO + 2) + WDO, 12'h0A7, exp_rdata});
    end
    repeat (2 * (WDO + 2) + 1) @(negedge clk);
    req = 1'b0;

    // Reset during WR, with cpu_req still asserted.
    wait_ready();
    req = 1'b1; we = 1'b1; addr = 12'h0B0; wdata = 16'hDEAD;
    t = cyc + 1;
    wq.push_back('{t, 12'h0B0, 16'hDEAD});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wr_ready", {31'd0, ready}, 32'd1);
    chk("abort_wr_mem_write", {31'd0, mwr}, 32'd0);
    reset = 1'b0; req = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during RD_WAIT: capture must not happen.
    wait_ready();
    req = 1'b1; we = 1'b0; addr = 12'h0A5;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rd_ready", {31'd0, ready}, 32'd1);
    chk("abort_rd_rdata", {16'd0, rdata}, 32'd0);
    reset = 1'b0; req = 1'b0; exp_rdata = 16'h0;
    repeat (4) @(negedge clk);

    for (int a = 0; a < 4096; a++) issue(1'b1, 12'(a), 16'(a), 16'h0);
    for (int a = 0; a < 4096; a++) issue(1'b0, 12'(a), 16'h0, 16'(a));

    // Forced readback corruption at 0x010.
    flip = 1'b1;
    issue(1'b1, 12'h010, 16'h5555, 16'h0);
    wait_ready();
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    chk("vfy_err_first", {31'd0, verr}, 32'd1);
    chk("vfy_cnt_first", {24'd0, vcnt}, 32'd1);
    for (int k = 0; k < 299; k++) issue(1'b1, 12'h010, 16'h5555, 16'h0);
    wait_ready();
    chk("vfy_err_sat", {31'd0, verr}, 32'd1);
    chk("vfy_cnt_sat", {24'd0, vcnt}, 32'd255);
`else
    chk("vfy_err_off", {31'd0, verr}, 32'd0);
    chk("vfy_cnt_off", {24'd0, vcnt}, 32'd0);
`endif
    flip = 1'b0;

    n = 0;
    while (!d3_fin && n < 500) begin @(negedge clk); n++; end
    chk("lat3_finished", {31'd0, d3_fin}, 32'd1);
    repeat (5) @(negedge clk);
    chk("wr_queue_drained", wq.size(), 32'd0);
    chk("done_queue_drained", dq.size(), 32'd0);
    chk("lat3_queue_drained", dq3.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, memory address width (4096 words).
REQ-002 Parameter DATA_W, default 16, memory word width.
REQ-003 Parameter RD_LAT, default 1, range 1-7, cycles from address presented to valid mem_outdata.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 cpu_req  input  1  request strobe, sampled only while cpu_ready=1.
REQ-007 cpu_we  input  1  1=write, 0=read; sampled with cpu_req.
REQ-008 cpu_addr  input  ADDR_W  request address.
REQ-009 cpu_wdata  input  DATA_W  write data.
REQ-010 cpu_ready  output  1  high only in IDLE.
REQ-011 cpu_done  output  1  one-cycle completion pulse.
REQ-012 cpu_rdata  output  DATA_W  read result, held until next read completes.
REQ-013 mem_adress  output  ADDR_W  registered address to memory.
REQ-014 mem_write  output  1  registered write enable to memory.
REQ-015 mem_indata  output  DATA_W  registered write data to memory.
REQ-016 mem_outdata  input  DATA_W  memory read data.
REQ-017 vfy_err  output  1  sticky verify-mismatch flag (VERIFY_EN only; tied 0 otherwise).
REQ-018 vfy_cnt  output  8  saturating mismatch count (VERIFY_EN only; tied 0 otherwise).

Function
REQ-019 FSM states: IDLE, WR, RD_WAIT, VFY_WAIT, DONE; one-hot or binary, implementer's choice.
REQ-020 IDLE with cpu_req=1 at edge T: latch cpu_addr→mem_adress, cpu_wdata→mem_indata, cpu_we; go WR if cpu_we else RD_WAIT; load wait counter with RD_LAT.
REQ-021 IDLE with cpu_req=0: remain IDLE; mem_write=0; mem_adress/mem_indata hold.
REQ-022 WR: mem_write=1 for exactly one cycle (T+1); next state DONE, or VFY_WAIT when VERIFY_EN.
REQ-023 RD_WAIT: decrement counter each cycle; on counter reaching 1, capture mem_outdata into cpu_rdata, go DONE; occupies exactly RD_LAT cycles.
REQ-024 DONE: cpu_done=1 for one cycle; return IDLE; cpu_ready=0 during DONE.
REQ-025 Latency: write cpu_done at cycle T+2 (no verify); read cpu_done at T+RD_LAT+1.
REQ-026 cpu_req while cpu_ready=0 ignored, no queuing; held cpu_req re-accepted at next IDLE cycle.
REQ-027 mem_write never asserted outside WR; mem_adress stable for whole transaction.
REQ-028 cpu_rdata unchanged by write transactions.
REQ-029 Address 0 and 2^ADDR_W-1 handled identically to others; no wrap logic.

Reset
REQ-030 reset=1 at edge: state IDLE, cpu_ready=1, cpu_done=0, mem_write=0, mem_adress=0, mem_indata=0, cpu_rdata=0, counter=0, vfy_err=0, vfy_cnt=0.
REQ-031 Reset mid-transaction aborts it: no cpu_done pulse, mem_write low from the first post-reset cycle, pending request discarded.
REQ-032 reset has priority over cpu_req in same cycle.

Configuration
REQ-033 Macro MEM_ACCESS_CTRL_VERIFY_EN: when defined, WR→VFY_WAIT, wait RD_LAT cycles at same address with mem_write=0, compare mem_outdata to mem_indata; mismatch sets vfy_err, increments vfy_cnt (saturates at 255); then DONE; write cpu_done at T+RD_LAT+2.
REQ-034 Macro undefined: VFY_WAIT unreachable/removed, vfy_err=0, vfy_cnt=0, write latency per REQ-025.

Verification
REQ-035 Reset 3 cycles → all outputs at REQ-030 values, cpu_ready=1.
REQ-036 Write addr 0x0A5, data 0x1234, RD_LAT=1 → mem_write high exactly cycle T+1 with mem_adress=0x0A5, mem_indata=0x1234; cpu_done at T+2 (T+3 with verify).
REQ-037 Read back 0x0A5 with behavioural memory model → cpu_rdata=0x1234, cpu_done at T+2; repeat RD_LAT=3 → cpu_done at T+4.
REQ-038 Fill all 4096 addresses with data=address, read all back → every cpu_rdata equals address; 0x000 and 0xFFF included.
REQ-039 cpu_req held high during busy → exactly one transaction per IDLE visit, no mem_write outside WR; reset asserted in WR/RD_WAIT → no cpu_done, IDLE next cycle.
REQ-040 VERIFY_EN, model forces bit 0 flip at 0x010 → vfy_err=1, vfy_cnt=1; 300 forced mismatches → vfy_cnt=255.
